// File: rtl/uart_tx_engine.sv
// FIFO-buffered UART transmitter with an integrated baud counter and back-to-back framing.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_engine #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_BITS-1:0]               wr_data,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic                               parity_odd,
    output logic                               tx,
    output logic                               busy,
    output logic                               tx_done,
    output logic                               fifo_full,
    output logic                               fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e                state_q;
    logic [DATA_BITS-1:0]  sreg_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  tx_q;
    logic                  done_q;
    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  bit_end;
    logic                  stop_end;
    logic                  push;
    logic                  pop;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign wr_ready   = !fifo_full;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign tx_done    = done_q;

    assign bit_end  = (baud_q == BAUD_LAST);
    assign stop_end = (state_q == STOP) && bit_end && (idx_q == STOP_LAST);
    assign push     = wr_valid && !fifo_full;
    // The last stop cycle reloads directly so consecutive frames have no idle gap.
    assign pop      = !fifo_empty && ((state_q == IDLE) || stop_end);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

`ifdef UART_TX_PARITY_EN
    logic par_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            baud_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            baud_q <= bit_end ? '0 : baud_q + BAUD_W'(1);
            if (pop) begin
                state_q <= START;
                sreg_q  <= mem_q[rd_ptr_q];
                baud_q  <= '0;
                idx_q   <= '0;
                tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par_q   <= (^mem_q[rd_ptr_q]) ^ parity_odd;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        baud_q <= '0;
                        tx_q   <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            state_q <= DATA;
                            tx_q    <= sreg_q[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (idx_q == DATA_LAST) begin
                                idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                                state_q <= PARITY;
                                tx_q    <= par_q;
`else
                                state_q <= STOP;
                                tx_q    <= 1'b1;
`endif
                            end else begin
                                idx_q  <= idx_q + IDX_W'(1);
                                sreg_q <= sreg_q >> 1;
                                tx_q   <= sreg_q[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            if (idx_q == STOP_LAST) state_q <= IDLE;
                            else                    idx_q   <= idx_q + IDX_W'(1);
                        end
                        // Registered strobe: raise it one cycle early so it lands on the final stop cycle.
                        if ((baud_q == BAUD_PRE) && (idx_q == STOP_LAST)) done_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: one-stop and two-stop instances share stimulus and a frame-level model.
module tb_uart_tx_engine;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       parity_odd = 1'b0;

    logic [1:0] tx_w, busy_w, done_w, full_w, empty_w, ready_w;
    logic [2:0] cnt_w [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(ready_w[0]),
        .parity_odd(parity_odd), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]),
        .fifo_full(full_w[0]), .fifo_empty(empty_w[0]), .fifo_count(cnt_w[0]));

    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(ready_w[1]),
        .parity_odd(parity_odd), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]),
        .fifo_full(full_w[1]), .fifo_empty(empty_w[1]), .fifo_count(cnt_w[1]));

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Model: each instance is a list of queued bytes plus the current frame as a bit list and a cycle position.
    int m_pos  [2] = '{-1, -1};
    int m_len  [2] = '{0, 0};
    int m_n    [2] = '{0, 0};
    int m_q    [2][DEPTH];
    int m_bits [2][16];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_pos[k] = -1;
                    m_n[k]   = 0;
                end else begin
                    logic       ld, acc;
                    logic [7:0] head;
                    int         nb;
                    ld  = (m_n[k] > 0) && (m_pos[k] < 0 || m_pos[k] == m_len[k] - 1);
                    acc = wr_valid && (m_n[k] < DEPTH);
                    if (ld) begin
                        head = 8'(m_q[k][0]);
                        for (int i = 0; i < DEPTH - 1; i++) m_q[k][i] = m_q[k][i+1];
                        m_n[k]--;
                        nb = 0;
                        m_bits[k][nb++] = 0;
                        for (int i = 0; i < 8; i++) m_bits[k][nb++] = int'(head[i]);
                        if (PAR == 1) m_bits[k][nb++] = int'((^head) ^ parity_odd);
                        for (int s = 0; s < k + 1; s++) m_bits[k][nb++] = 1;
                        m_len[k] = nb * CPB;
                        m_pos[k] = 0;
                    end else if (m_pos[k] >= 0) begin
                        if (m_pos[k] == m_len[k] - 1) m_pos[k] = -1;
                        else                          m_pos[k]++;
                    end
                    if (acc) begin
                        m_q[k][m_n[k]] = int'(wr_data);
                        m_n[k]++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [8:0] act, expv;
                logic       etx;
                etx  = (m_pos[k] < 0) ? 1'b1 : m_bits[k][m_pos[k] / CPB][0];
                expv = {etx, m_pos[k] >= 0, (m_pos[k] >= 0) && (m_pos[k] == m_len[k] - 1),
                        m_n[k] == DEPTH, m_n[k] == 0, m_n[k] != DEPTH, 3'(m_n[k])};
                act  = {tx_w[k], busy_w[k], done_w[k], full_w[k], empty_w[k], ready_w[k], cnt_w[k]};
                n_tests++;
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL model_cmp dut%0d: got %b expected %b (tx,busy,done,full,empty,ready,cnt) at %0t",
                             k, act, expv, $time);
                end
            end
        end
    end

    // One frame from an empty, idle state; expf holds the one-stop frame, bit 0 = start bit.
    task automatic run_frame(input logic [7:0] d, input logic po, input logic [12:0] expf, input int nb);
        int len0, len1;
        len0 = nb * CPB;
        len1 = (nb + 1) * CPB;
        wr_data = d; wr_valid = 1'b1; parity_odd = po;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("preload_tx", int'(tx_w[0]), 1);
        chk("preload_cnt", int'(cnt_w[0]), 1);
        for (int cyc = 1; cyc <= len1 + 1; cyc++) begin
            @(negedge clk);
            if (cyc <= len0)      chk("frame_tx0", int'(tx_w[0]), int'(expf[(cyc-1)/CPB]));
            if (cyc == 1)         chk("busy_rise", int'(busy_w[0]), 1);
            if (cyc == len0 - 1)  chk("done0_early", int'(done_w[0]), 0);
            if (cyc == len0)      chk("done0_last", int'(done_w[0]), 1);
            if (cyc == len0 + 1)  chk("busy0_drop", int'(busy_w[0]), 0);
            if (cyc > (nb - 1) * CPB && cyc <= len1) chk("stop2_tx1", int'(tx_w[1]), 1);
            if (cyc == len1 - 1)  chk("done1_early", int'(done_w[1]), 0);
            if (cyc == len1)      chk("done1_last", int'(done_w[1]), 1);
            if (cyc == len1 + 1)  chk("busy1_drop", int'(busy_w[1]), 0);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy_w != 2'b00 || empty_w != 2'b11) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", int'(n < budget), 1);
    endtask

    initial begin
        int n_done, gaps, busy_seen;

        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", int'(tx_w[0]), 1);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_done", int'(done_w[0]), 0);
        chk("rst_empty", int'(empty_w[0]), 1);
        chk("rst_cnt", int'(cnt_w[0]), 0);
        chk("rst_ready", int'(ready_w[0]), 1);

`ifdef UART_TX_PARITY_EN
        run_frame(8'hA5, 1'b0, 13'b1_0_1010_0101_0, 11);
        run_frame(8'h07, 1'b0, 13'b1_1_0000_0111_0, 11);
        run_frame(8'h07, 1'b1, 13'b1_0_0000_0111_0, 11);
        run_frame(8'hFF, 1'b0, 13'b1_0_1111_1111_0, 11);
`else
        run_frame(8'hA5, 1'b0, 13'b1_1010_0101_0, 10);
        run_frame(8'h07, 1'b0, 13'b1_0000_0111_0, 10);
        run_frame(8'h07, 1'b1, 13'b1_0000_0111_0, 10);
        run_frame(8'hFF, 1'b0, 13'b1_1111_1111_0, 10);
`endif

        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'h11 * (i + 1));
            @(negedge clk);
            if (i == 4) begin
                chk("full_flag", int'(full_w[0]), 1);
                chk("full_ready", int'(ready_w[0]), 0);
                chk("full_cnt", int'(cnt_w[0]), 4);
            end
            if (i == 5) chk("drop_cnt", int'(cnt_w[0]), 4);
        end
        wr_valid = 1'b0;
        n_done = 0;
        gaps = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (n_done == 5 && busy_w[0] == 1'b0) break;
            if (done_w[0]) n_done++;
            if (!busy_w[0] && n_done < 5) gaps++;
            @(negedge clk);
        end
        chk("b2b_frames", n_done, 5);
        chk("b2b_gaps", gaps, 0);
        wait_idle(400);

        wr_valid = 1'b1;
        wr_data = 8'h00; @(negedge clk);
        wr_data = 8'h5A; @(negedge clk);
        wr_data = 8'hC3; @(negedge clk);
        wr_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_tx", int'(tx_w[0]), 0);
        chk("pre_rst_cnt", int'(cnt_w[0]), 2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", int'(tx_w[0]), 1);
        chk("midrst_cnt", int'(cnt_w[0]), 0);
        chk("midrst_busy", int'(busy_w[0]), 0);
        chk("midrst_empty", int'(empty_w[0]), 1);
        chk("midrst_ready", int'(ready_w[0]), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        busy_seen = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (busy_w != 2'b00 || tx_w != 2'b11) busy_seen++;
        end
        chk("post_rst_quiet", busy_seen, 0);

`ifdef UART_TX_PARITY_EN
        run_frame(8'h3C, 1'b1, 13'b1_1_0011_1100_0, 11);
`else
        run_frame(8'h3C, 1'b1, 13'b1_0011_1100_0, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmit engine: accepts bytes over a valid/ready write port into an internal FIFO and serialises them onto `tx` as start / data (LSB first) / optional parity / stop bits at a fixed clocks-per-bit rate. It sits between the core-side bus adapter and the pad. It generalises the earlier fixed-format TX controller with these additions:
- configurable data width, stop bits and FIFO depth
- an integrated baud counter
- back-to-back framing and a frame-done strobe

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame; legal 5..9.
- `CLKS_PER_BIT`, 16: clock cycles per bit period; ≥2.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_data` in DATA_BITS: byte to enqueue.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: FIFO can accept; equals `!fifo_full`.
- `parity_odd` in 1: 1 = odd parity, 0 = even; sampled when a frame is loaded.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high whenever the FSM is not IDLE.
- `tx_done` out 1: one-cycle pulse at the end of each frame's last stop bit.
- `fifo_full` out 1: FIFO full flag.
- `fifo_empty` out 1: FIFO empty flag.
- `fifo_count` out $clog2(FIFO_DEPTH+1): current number of entries.

## Operation
- **Write:** accepted on a rising edge with `wr_valid && wr_ready`. Data goes to the write pointer, and both the pointer and the count increment. A write while full is dropped, with no state change.
- **Pointers:** $clog2(FIFO_DEPTH) bits, natural wrap-around. `fifo_full` is `count==FIFO_DEPTH`; `fifo_empty` is `count==0`.
- **Pop:** occurs only on a frame load. On a cycle with both an accepted write and a pop, the count is unchanged. A pop and a write to the same slot cannot occur, because a pop needs non-empty and a write needs non-full.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx=1`. If `!fifo_empty`, the FSM pops the head into the shift register, latches `parity_odd`, clears the baud counter and bit index, drives `tx<=0` and moves to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then DATA with `tx<=sreg[0]`.
  - DATA: each bit is held CLKS_PER_BIT cycles, then the register shifts right. After DATA_BITS bits the FSM goes to PARITY when the macro is enabled, otherwise to STOP.
  - PARITY: `tx` = XOR of the data bits XOR the latched `parity_odd`, held one bit period.
  - STOP: `tx=1` for STOP_BITS×CLKS_PER_BIT cycles. In the final cycle `tx_done` pulses. If the FIFO is non-empty, the FSM loads the next entry and goes straight to START with no idle gap; otherwise it returns to IDLE.
- **Baud counter:** 0..CLKS_PER_BIT-1. It resets on every bit boundary and on every frame load.
- **Output registration:** `tx` is registered and changes only on a bit boundary or a frame load.
- **Reset:** asserting `rst` at any time, including mid-frame, immediately forces the following. Any in-flight frame is abandoned.
  - FSM to IDLE
  - `tx=1`, `busy=0`, `tx_done=0`
  - pointers and count to 0, so `fifo_empty=1`, `fifo_full=0`, `wr_ready=1`

## Timing
- Write accepted at edge E into an empty FIFO with the FSM IDLE: the frame loads at E+1, `tx` falls after E+1, and `busy` rises after E+1.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)×CLKS_PER_BIT cycles, with P = 1 when the macro is enabled and 0 otherwise.
- `tx_done` is high for exactly one cycle, in the last cycle of the frame.
- `wr_ready` depends combinationally on the registered count only, never on `wr_valid`.
- The count and flags update on the edge after the write or pop.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is present, frames carry one parity bit, and `parity_odd` selects the polarity.
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are removed, DATA goes directly to STOP, and `parity_odd` is ignored but the port remains.

## Test plan
All scenarios use DATA_BITS=8, CLKS_PER_BIT=4, STOP_BITS=1, FIFO_DEPTH=4 unless stated otherwise.
- **Reset values:** after `rst`, `tx=1`, `busy=0`, `tx_done=0`, `fifo_empty=1`, `fifo_count=0`, `wr_ready=1`.
- **Single frame, parity disabled:** write 0xA5 → `tx` falls one cycle after the write, then carries 0 / 1,0,1,0,0,1,0,1 / 1, each bit held 4 cycles. `tx_done` pulses in cycle 40 of the frame, and `busy` drops the cycle after.
- **Parity enabled:** write 0x07 with `parity_odd=0` → parity bit 1. Write 0x07 with `parity_odd=1` → parity bit 0. Frame length is 44 cycles.
- **Full FIFO:** 6 writes in consecutive cycles while idle → the first frame loads one entry. `fifo_full` asserts, `wr_ready=0`, and the last write is dropped. Five frames are transmitted back-to-back with no idle cycle between the stop bit and the next start bit.
- **STOP_BITS=2:** write 0xFF → the stop phase lasts 8 cycles at `tx=1`, and `tx_done` pulses in the final stop cycle.
- **Mid-frame reset:** assert `rst` during a DATA bit while `tx=0` with 2 entries queued → `tx=1` immediately, `fifo_count=0`. No frame follows after `rst` deasserts until a new write.
